// File: rtl/xif_arbiter.sv
// Two-master round-robin arbiter for the split-transaction peripheral bus, with an in-order read-ID FIFO.
// Optional sticky protocol-error output err_o is enabled with the XIF_ARB_ERRCHK_EN macro.
module xif_arbiter #(
  parameter int RD_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_bi,
  input  logic [3:0]        m0_be_bi,
  input  logic [31:0]       m0_wdata_bi,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [31:0]       m0_rdata_bo,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_bi,
  input  logic [3:0]        m1_be_bi,
  input  logic [31:0]       m1_wdata_bi,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [31:0]       m1_rdata_bo,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_bo,
  output logic [3:0]        s_be_bo,
  output logic [31:0]       s_wdata_bo,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
`ifdef XIF_ARB_ERRCHK_EN
  input  logic [31:0]       s_rdata_bi,
  output logic              err_o
`else
  input  logic [31:0]       s_rdata_bi
`endif
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RD_DEPTH);

  logic                rr_last_q;
  logic                lock_q;
  logic                lock_idx_q;
  logic [RD_DEPTH-1:0] fifo_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic fifo_full, fifo_empty;
  logic elig0, elig1;
  logic gnt_vld, gnt_idx;
  logic xfer, push, pop, head;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // Writes bypass the FIFO-full check; they never produce a response.
  assign elig0 = m0_req_i & (m0_we_i | ~fifo_full);
  assign elig1 = m1_req_i & (m1_we_i | ~fifo_full);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (lock_q) begin
      gnt_idx = lock_idx_q;
      gnt_vld = lock_idx_q ? m1_req_i : m0_req_i;
    end else if (elig0 && elig1) begin
      gnt_vld = 1'b1;
      gnt_idx = ~rr_last_q;
    end else if (elig0) begin
      gnt_vld = 1'b1;
    end else if (elig1) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  always_comb begin
    s_req_o    = gnt_vld;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (gnt_vld) begin
      s_we_o     = gnt_idx ? m1_we_i     : m0_we_i;
      s_addr_bo  = gnt_idx ? m1_addr_bi  : m0_addr_bi;
      s_be_bo    = gnt_idx ? m1_be_bi    : m0_be_bi;
      s_wdata_bo = gnt_idx ? m1_wdata_bi : m0_wdata_bi;
    end
  end

  assign xfer = s_req_o & s_ack_i;
  assign push = xfer & ~s_we_o;
  assign pop  = s_resp_i & ~fifo_empty;
  assign head = fifo_q[rd_ptr_q];

  assign m0_ack_o    = xfer & ~gnt_idx;
  assign m1_ack_o    = xfer &  gnt_idx;
  assign m0_resp_o   = pop & ~head;
  assign m1_resp_o   = pop &  head;
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  // rr_last resets to 1 so that m0 wins the first contended grant.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rr_last_q  <= 1'b1;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
    end else if (xfer) begin
      rr_last_q <= gnt_idx;
      lock_q    <= 1'b0;
    end else if (gnt_vld) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt_idx;
    end else begin
      lock_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef XIF_ARB_ERRCHK_EN
  logic err_q;
  logic lock_drop;

  // A locked master that lets go of req before being acked is a protocol violation.
  assign lock_drop = lock_q & ~(lock_idx_q ? m1_req_i : m0_req_i);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) err_q <= 1'b0;
    else if ((s_resp_i && fifo_empty) || lock_drop) err_q <= 1'b1;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_xif_arbiter.sv
// Directed bench for xif_arbiter: grant order, lock, read-FIFO routing, unexpected responses.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_xif_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_bi, m1_addr_bi, m0_wdata_bi, m1_wdata_bi;
  logic [3:0]  m0_be_bi, m1_be_bi;
  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;
`ifdef XIF_ARB_ERRCHK_EN
  logic        err_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  xif_arbiter #(.RD_DEPTH(4), .ADDR_W(32)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
    .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i),
`ifdef XIF_ARB_ERRCHK_EN
    .s_rdata_bi(s_rdata_bi), .err_o(err_o)
`else
    .s_rdata_bi(s_rdata_bi)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m0_addr_bi = '0; m0_be_bi = '0; m0_wdata_bi = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_bi = '0; m1_be_bi = '0; m1_wdata_bi = '0;
    s_ack_i = 0; s_resp_i = 0; s_rdata_bi = '0;
  endtask

  task automatic next();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    next();
    arst_i = 1'b1;
    idle();
    settle();
    check("rst_s_req", 32'(s_req_o), 0);
    check("rst_m0_ack", 32'(m0_ack_o), 0);
    check("rst_m1_resp", 32'(m1_resp_o), 0);
    check("rst_m0_rdata", m0_rdata_bo, 0);
`ifdef XIF_ARB_ERRCHK_EN
    check("rst_err", 32'(err_o), 0);
`endif
    next();
    arst_i = 1'b0;
  endtask

  initial begin
    arst_i = 1'b1;
    idle();
    do_reset();

    // m0 single read, response one cycle later
    next();
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h8000_0004; m0_be_bi = 4'hF; s_ack_i = 1;
    settle();
    check("t1_m0_ack", 32'(m0_ack_o), 1);
    check("t1_m1_ack", 32'(m1_ack_o), 0);
    check("t1_s_addr", s_addr_bo, 32'h8000_0004);
    check("t1_s_we", 32'(s_we_o), 0);
    next();
    m0_req_i = 0; s_ack_i = 0; s_resp_i = 1; s_rdata_bi = 32'h0000_00A5;
    settle();
    check("t1_m0_resp", 32'(m0_resp_o), 1);
    check("t1_m0_rdata", m0_rdata_bo, 32'hA5);
    check("t1_m1_resp", 32'(m1_resp_o), 0);
    check("t1_m1_rdata", m1_rdata_bo, 0);
    next();
    s_resp_i = 0;
    settle();
    check("t1_m0_resp_off", 32'(m0_resp_o), 0);
    check("t1_m0_rdata_off", m0_rdata_bo, 0);

    // continuous writes from both masters alternate, starting with m0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next();
      m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h8000_0000; m0_wdata_bi = 32'h100; m0_be_bi = 4'hF;
      m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h8000_0000; m1_wdata_bi = 32'h200; m1_be_bi = 4'h3;
      s_ack_i = 1;
      settle();
      check("t2_m0_ack", 32'(m0_ack_o), (i % 2 == 0) ? 1 : 0);
      check("t2_m1_ack", 32'(m1_ack_o), (i % 2 == 0) ? 0 : 1);
      check("t2_wdata", s_wdata_bo, (i % 2 == 0) ? 32'h100 : 32'h200);
      check("t2_be", 32'(s_be_bo), (i % 2 == 0) ? 32'hF : 32'h3);
    end

    // m1 fills the read FIFO; 5th read stalls, writes still pass
    next();
    idle();
    for (int i = 0; i < 4; i++) begin
      m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h8000_0010 + 32'(i); s_ack_i = 1;
      settle();
      check("t3_fill_ack", 32'(m1_ack_o), 1);
      next();
    end
    m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h8000_0020;
    settle();
    check("t3_full_m1_ack", 32'(m1_ack_o), 0);
    check("t3_full_m0_ack", 32'(m0_ack_o), 1);
    check("t3_full_s_we", 32'(s_we_o), 1);
    next();
    m0_req_i = 0; s_resp_i = 1; s_rdata_bi = 32'h33;
    settle();
    check("t3_pop_m1_resp", 32'(m1_resp_o), 1);
    check("t3_pop_rdata", m1_rdata_bo, 32'h33);
    check("t3_nobypass_ack", 32'(m1_ack_o), 0);
    check("t3_nobypass_req", 32'(s_req_o), 0);
    next();
    s_resp_i = 0;
    settle();
    check("t3_5th_ack", 32'(m1_ack_o), 1);
    next();
    m1_req_i = 0; s_resp_i = 1;
    for (int i = 0; i < 4; i++) begin
      s_rdata_bi = 32'h40 + 32'(i);
      settle();
      check("t3_drain_resp", 32'(m1_resp_o), 1);
      check("t3_drain_rdata", m1_rdata_bo, 32'h40 + 32'(i));
      check("t3_drain_m0", 32'(m0_resp_o), 0);
      next();
    end
    s_resp_i = 0;
    settle();
    check("t3_drained", 32'(m1_resp_o), 0);

    // interleaved reads return in acceptance order
    next();
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h8000_0030;
    m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h8000_0034; s_ack_i = 1;
    settle();
    check("t4_first_m0", 32'(m0_ack_o), 1);
    check("t4_first_m1", 32'(m1_ack_o), 0);
    next();
    m0_req_i = 0;
    settle();
    check("t4_second_m1", 32'(m1_ack_o), 1);
    next();
    m1_req_i = 0; s_ack_i = 0; s_resp_i = 1; s_rdata_bi = 32'h11;
    settle();
    check("t4_r0_m0", m0_rdata_bo, 32'h11);
    check("t4_r0_m1", 32'(m1_resp_o), 0);
    next();
    s_rdata_bi = 32'h22;
    settle();
    check("t4_r1_m1", m1_rdata_bo, 32'h22);
    check("t4_r1_m0", 32'(m0_resp_o), 0);
    next();
    s_resp_i = 0;

    // lock: m0 held through 3 stalled cycles even though m1 would win round-robin
    m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h8000_0090; s_ack_i = 1;
    settle();
    check("t5_pre_ack", 32'(m0_ack_o), 1);
    next();
    m0_addr_bi = 32'h8000_00A0; s_ack_i = 0;
    settle();
    check("t5_c0_addr", s_addr_bo, 32'h8000_00A0);
    check("t5_c0_ack", 32'(m0_ack_o), 0);
    for (int i = 1; i < 3; i++) begin
      next();
      m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h8000_00B0;
      settle();
      check("t5_lock_addr", s_addr_bo, 32'h8000_00A0);
      check("t5_lock_m1_ack", 32'(m1_ack_o), 0);
    end
    next();
    s_ack_i = 1;
    settle();
    check("t5_m0_ack", 32'(m0_ack_o), 1);
    check("t5_m0_addr", s_addr_bo, 32'h8000_00A0);
    next();
    m0_req_i = 0;
    settle();
    check("t5_m1_ack", 32'(m1_ack_o), 1);
    check("t5_m1_addr", s_addr_bo, 32'h8000_00B0);
    next();
    idle();
`ifdef XIF_ARB_ERRCHK_EN
    settle();
    check("t6_err_before", 32'(err_o), 0);
`endif

    // unexpected response with empty FIFO is dropped
    next();
    s_resp_i = 1; s_rdata_bi = 32'hDEAD_BEEF;
    settle();
    check("t6_m0_resp", 32'(m0_resp_o), 0);
    check("t6_m1_resp", 32'(m1_resp_o), 0);
    check("t6_m0_rdata", m0_rdata_bo, 0);
    check("t6_m1_rdata", m1_rdata_bo, 0);
    next();
    s_resp_i = 0;
`ifdef XIF_ARB_ERRCHK_EN
    settle();
    check("t6_err_set", 32'(err_o), 1);
    next(); next(); next();
    check("t6_err_sticky", 32'(err_o), 1);
    do_reset();
    settle();
    check("t6_err_cleared", 32'(err_o), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
